// File: rtl/uart_tx_fifo.sv
// UART transmitter with an integrated TX FIFO. The frame format (data bits, parity,
// stop bits) and the baud divisor are fixed by parameters.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic [DATA_BITS-1:0]            i_data,
  input  logic                            i_wr,
  output logic                            o_full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] o_count,
  output logic                            o_busy,
  output logic                            o_done,
  output logic                            o_serialTX
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = 4;
  localparam logic [BAUD_W-1:0] BAUD_LOAD = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t r_state;
  state_t w_stateNext;

  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     r_wrPtr;
  logic [PTR_W-1:0]     r_rdPtr;
  logic [CNT_W-1:0]     r_count;
  logic [BAUD_W-1:0]    r_baud;
  logic [BIT_W-1:0]     r_bitCnt;
  logic [DATA_BITS-1:0] r_shreg;
  logic                 r_parBit;
  logic                 r_tx;
  logic                 r_done;

  logic w_full;
  logic w_wrAccept;
  logic w_pop;
  logic w_bitEnd;
  logic w_frameEnd;

  assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_wrAccept = i_wr && !w_full;
  assign w_bitEnd   = (r_baud == '0);

  always_ff @(posedge i_clk) begin
    if (!i_rst) r_state <= S_IDLE;
    else        r_state <= w_stateNext;
  end

  // The next frame is popped on the same edge the last stop bit ends, so frames abut.
  always_comb begin
    w_stateNext = r_state;
    w_pop       = 1'b0;
    w_frameEnd  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_pop       = 1'b1;
          w_stateNext = S_START;
        end
      end
      S_START: begin
        if (w_bitEnd) w_stateNext = S_DATA;
      end
      S_DATA: begin
        if (w_bitEnd && r_bitCnt == BIT_W'(DATA_BITS - 1))
          w_stateNext = (PARITY != 0) ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        if (w_bitEnd) w_stateNext = S_STOP;
      end
      S_STOP: begin
        if (w_bitEnd && r_bitCnt == BIT_W'(STOP_BITS - 1)) begin
          w_frameEnd = 1'b1;
          if (r_count != '0) begin
            w_pop       = 1'b1;
            w_stateNext = S_START;
          end else begin
            w_stateNext = S_IDLE;
          end
        end
      end
      default: w_stateNext = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_wrAccept) r_mem[r_wrPtr] <= i_data;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_wrAccept) r_wrPtr <= r_wrPtr + PTR_W'(1);
      if (w_pop)      r_rdPtr <= r_rdPtr + PTR_W'(1);
      case ({w_wrAccept, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Parity is captured at pop time so later FIFO writes cannot disturb the frame.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_baud   <= '0;
      r_bitCnt <= '0;
      r_shreg  <= '0;
      r_parBit <= 1'b0;
    end else begin
      if (w_pop)
        r_baud <= BAUD_LOAD;
      else if (r_state != S_IDLE)
        r_baud <= w_bitEnd ? BAUD_LOAD : r_baud - BAUD_W'(1);

      if (w_stateNext != r_state)
        r_bitCnt <= '0;
      else if (w_bitEnd && (r_state == S_DATA || r_state == S_STOP))
        r_bitCnt <= r_bitCnt + BIT_W'(1);

      if (w_pop) begin
        r_shreg  <= r_mem[r_rdPtr];
        r_parBit <= (^r_mem[r_rdPtr]) ^ (PARITY == 1);
      end else if (r_state == S_DATA && w_bitEnd) begin
        r_shreg <= r_shreg >> 1;
      end
    end
  end

  // The line is registered from the current state, so it trails the FSM by one cycle.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_tx   <= 1'b1;
      r_done <= 1'b0;
    end else begin
      r_done <= w_frameEnd;
      case (r_state)
        S_START:  r_tx <= 1'b0;
        S_DATA:   r_tx <= r_shreg[0];
        S_PARITY: r_tx <= r_parBit;
        default:  r_tx <= 1'b1;
      endcase
    end
  end

  assign o_full     = w_full;
  assign o_count    = r_count;
  assign o_busy     = (r_state != S_IDLE) || (r_count != '0);
  assign o_done     = r_done;
  assign o_serialTX = r_tx;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: several instances with different frame formats
// and FIFO depths, all at 4 clocks per bit, checked against hand-built bit streams.
module tb_uart_tx_fifo;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  bit   expQ[$];
  bit   expE[$];
  bit   expO[$];

  // 8N1, depth 8
  logic [7:0] aData;
  logic       aWr, aFull, aBusy, aDone, aTx;
  logic [3:0] aCount;
  // 8E1
  logic [7:0] eData;
  logic       eWr, eFull, eBusy, eDone, eTx;
  logic [3:0] eCount;
  // 8O2
  logic [7:0] oData;
  logic       oWr, oFull, oBusy, oDone, oTx;
  logic [3:0] oCount;
  // 8N1, depth 4
  logic [7:0] fData;
  logic       fWr, fFull, fBusy, fDone, fTx;
  logic [2:0] fCount;

  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(8)) u_dutA (
    .i_clk(clk), .i_rst(rst), .i_data(aData), .i_wr(aWr), .o_full(aFull),
    .o_count(aCount), .o_busy(aBusy), .o_done(aDone), .o_serialTX(aTx));

  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(8)) u_dutE (
    .i_clk(clk), .i_rst(rst), .i_data(eData), .i_wr(eWr), .o_full(eFull),
    .o_count(eCount), .o_busy(eBusy), .o_done(eDone), .o_serialTX(eTx));

  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(8)) u_dutO (
    .i_clk(clk), .i_rst(rst), .i_data(oData), .i_wr(oWr), .o_full(oFull),
    .o_count(oCount), .o_busy(oBusy), .o_done(oDone), .o_serialTX(oTx));

  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dutF (
    .i_clk(clk), .i_rst(rst), .i_data(fData), .i_wr(fWr), .o_full(fFull),
    .o_count(fCount), .o_busy(fBusy), .o_done(fDone), .o_serialTX(fTx));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Appends one frame's line levels (one entry per bit period) to expQ.
  function automatic void pushFrame(input logic [7:0] d, input int par, input int stops);
    expQ.push_back(1'b0);
    for (int i = 0; i < 8; i++) expQ.push_back(d[i]);
    if (par != 0) expQ.push_back((^d) ^ (par == 1));
    for (int i = 0; i < stops; i++) expQ.push_back(1'b1);
  endfunction

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) tick;
    checks++; if (aTx !== 1'b1) begin errors++; $display("[TB] FAIL reset_tx: got %b want 1", aTx); end
    checks++; if (aBusy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", aBusy); end
    checks++; if (aDone !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b want 0", aDone); end
    checks++; if (aCount !== 4'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d want 0", aCount); end
    checks++; if (aFull !== 1'b0) begin errors++; $display("[TB] FAIL reset_full: got %b want 0", aFull); end
    checks++; if ({eTx, oTx, fTx} !== 3'b111) begin errors++; $display("[TB] FAIL reset_tx_others: got %b want 111", {eTx, oTx, fTx}); end
    rst = 1'b1;
    tick;
  endtask

  task automatic test_frame_8n1;
    expQ.delete();
    pushFrame(8'hA5, 0, 1);
    aData = 8'hA5; aWr = 1'b1;
    tick;
    aWr = 1'b0;
    checks++; if (aCount !== 4'd1) begin errors++; $display("[TB] FAIL 8n1_count_after_write: got %0d want 1", aCount); end
    tick;
    checks++; if (aTx !== 1'b1) begin errors++; $display("[TB] FAIL 8n1_line_before_start: got %b want 1", aTx); end
    checks++; if (aBusy !== 1'b1) begin errors++; $display("[TB] FAIL 8n1_busy: got %b want 1", aBusy); end
    for (int i = 0; i < 40; i++) begin
      tick;
      checks++; if (aTx !== expQ[i/4]) begin errors++; $display("[TB] FAIL 8n1_line cycle %0d: got %b want %b", i, aTx, expQ[i/4]); end
      checks++; if (aDone !== (i == 39)) begin errors++; $display("[TB] FAIL 8n1_done cycle %0d: got %b want %b", i, aDone, (i == 39)); end
    end
    tick;
    checks++; if ({aTx, aDone, aBusy} !== 3'b100) begin errors++; $display("[TB] FAIL 8n1_after_frame tx/done/busy: got %b want 100", {aTx, aDone, aBusy}); end
  endtask

  // Even-parity 1-stop and odd-parity 2-stop instances run side by side.
  task automatic test_parity;
    expQ.delete(); pushFrame(8'hA5, 2, 1); expE = expQ;
    expQ.delete(); pushFrame(8'hA5, 1, 2); expO = expQ;
    eData = 8'hA5; oData = 8'hA5; eWr = 1'b1; oWr = 1'b1;
    tick;
    eWr = 1'b0; oWr = 1'b0;
    tick;
    for (int i = 0; i < 48; i++) begin
      tick;
      if (i < 44) begin
        checks++; if (eTx !== expE[i/4]) begin errors++; $display("[TB] FAIL even_line cycle %0d: got %b want %b", i, eTx, expE[i/4]); end
        checks++; if (eDone !== (i == 43)) begin errors++; $display("[TB] FAIL even_done cycle %0d: got %b want %b", i, eDone, (i == 43)); end
      end
      checks++; if (oTx !== expO[i/4]) begin errors++; $display("[TB] FAIL odd2_line cycle %0d: got %b want %b", i, oTx, expO[i/4]); end
      checks++; if (oDone !== (i == 47)) begin errors++; $display("[TB] FAIL odd2_done cycle %0d: got %b want %b", i, oDone, (i == 47)); end
    end
    tick;
    checks++; if ({eBusy, oBusy} !== 2'b00) begin errors++; $display("[TB] FAIL parity_busy_after: got %b want 00", {eBusy, oBusy}); end
  endtask

  task automatic test_back_to_back;
    int doneCnt;
    doneCnt = 0;
    expQ.delete();
    pushFrame(8'h11, 0, 1); pushFrame(8'h22, 0, 1); pushFrame(8'h33, 0, 1);
    aData = 8'h11; aWr = 1'b1;
    tick;
    checks++; if (aCount !== 4'd1) begin errors++; $display("[TB] FAIL b2b_count_w1: got %0d want 1", aCount); end
    aData = 8'h22;
    tick;
    checks++; if (aCount !== 4'd1) begin errors++; $display("[TB] FAIL b2b_count_w2: got %0d want 1", aCount); end
    aData = 8'h33;
    for (int i = 0; i < 120; i++) begin
      tick;
      aWr = 1'b0;
      if (aDone === 1'b1) doneCnt++;
      if (i == 0) begin
        checks++; if (aCount !== 4'd2) begin errors++; $display("[TB] FAIL b2b_count_w3: got %0d want 2", aCount); end
      end
      if (i == 39) begin
        checks++; if (aCount !== 4'd1) begin errors++; $display("[TB] FAIL b2b_count_pop2: got %0d want 1", aCount); end
      end
      if (i == 79) begin
        checks++; if (aCount !== 4'd0) begin errors++; $display("[TB] FAIL b2b_count_pop3: got %0d want 0", aCount); end
      end
      checks++; if (aTx !== expQ[i/4]) begin errors++; $display("[TB] FAIL b2b_line cycle %0d: got %b want %b", i, aTx, expQ[i/4]); end
      checks++; if (aDone !== (i % 40 == 39)) begin errors++; $display("[TB] FAIL b2b_done cycle %0d: got %b want %b", i, aDone, (i % 40 == 39)); end
    end
    tick;
    checks++; if (doneCnt != 3) begin errors++; $display("[TB] FAIL b2b_done_pulses: got %0d want 3", doneCnt); end
    checks++; if ({aTx, aBusy} !== 2'b10) begin errors++; $display("[TB] FAIL b2b_idle_after tx/busy: got %b want 10", {aTx, aBusy}); end
  endtask

  task automatic test_fifo_full;
    logic [7:0] d [6];
    int doneCnt;
    d = '{8'h3C, 8'h81, 8'h5A, 8'hF0, 8'h0F, 8'hFF};
    doneCnt = 0;
    expQ.delete();
    for (int k = 0; k < 5; k++) pushFrame(d[k], 0, 1);
    fData = d[0]; fWr = 1'b1;
    tick;
    checks++; if ({fCount, fFull} !== {3'd1, 1'b0}) begin errors++; $display("[TB] FAIL full_first_write count/full: got %0d/%b want 1/0", fCount, fFull); end
    fData = d[1];
    tick;
    for (int i = 0; i < 200; i++) begin
      if (i < 4) begin fData = d[i+2]; fWr = 1'b1; end
      else fWr = 1'b0;
      tick;
      if (fDone === 1'b1) doneCnt++;
      if (i == 2 || i == 3) begin
        checks++; if ({fCount, fFull} !== {3'd4, 1'b1}) begin errors++; $display("[TB] FAIL full_flag cycle %0d count/full: got %0d/%b want 4/1", i, fCount, fFull); end
      end
      if (i == 39) begin
        checks++; if ({fCount, fFull} !== {3'd3, 1'b0}) begin errors++; $display("[TB] FAIL full_after_pop count/full: got %0d/%b want 3/0", fCount, fFull); end
      end
      checks++; if (fTx !== expQ[i/4]) begin errors++; $display("[TB] FAIL full_line cycle %0d: got %b want %b", i, fTx, expQ[i/4]); end
    end
    for (int i = 0; i < 60; i++) begin
      tick;
      if (fDone === 1'b1) doneCnt++;
      checks++; if (fTx !== 1'b1) begin errors++; $display("[TB] FAIL full_dropped_not_sent cycle %0d: got %b want 1", i, fTx); end
    end
    checks++; if (doneCnt != 5) begin errors++; $display("[TB] FAIL full_frames: got %0d want 5", doneCnt); end
    checks++; if ({fBusy, fCount} !== {1'b0, 3'd0}) begin errors++; $display("[TB] FAIL full_idle busy/count: got %b/%0d want 0/0", fBusy, fCount); end
  endtask

  task automatic test_reset_midframe;
    aData = 8'h00; aWr = 1'b1;
    repeat (3) tick;
    aWr = 1'b0;
    repeat (8) tick;
    checks++; if (aTx !== 1'b0) begin errors++; $display("[TB] FAIL midrst_line_before: got %b want 0", aTx); end
    checks++; if (aCount !== 4'd2) begin errors++; $display("[TB] FAIL midrst_count_before: got %0d want 2", aCount); end
    rst = 1'b0;
    tick;
    rst = 1'b1;
    checks++; if (aTx !== 1'b1) begin errors++; $display("[TB] FAIL midrst_line: got %b want 1", aTx); end
    checks++; if ({aCount, aFull, aBusy, aDone} !== 7'd0) begin errors++; $display("[TB] FAIL midrst_state count/full/busy/done: got %0d/%b/%b/%b want 0/0/0/0", aCount, aFull, aBusy, aDone); end
    for (int i = 0; i < 100; i++) begin
      tick;
      checks++; if ({aTx, aDone} !== 2'b10) begin errors++; $display("[TB] FAIL midrst_quiet cycle %0d tx/done: got %b want 10", i, {aTx, aDone}); end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    aData = '0; aWr = 1'b0;
    eData = '0; eWr = 1'b0;
    oData = '0; oWr = 1'b0;
    fData = '0; fWr = 1'b0;
    test_reset;
    test_frame_8n1;
    test_parity;
    test_back_to_back;
    test_fifo_full;
    test_reset_midframe;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
